// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore control FSM for a multicycle MIPS-subset datapath.
//                Sequences fetch/decode/execute/writeback, waits on memory
//                handshakes and traps unsupported encodings into a sticky
//                ILLEGAL state.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        neg,
    input  logic        mem_ready,
    output logic        memread,
    output logic        memwrite,
    output logic        iord,
    output logic        irwrite,
    output logic        pcwrite,
    output logic [1:0]  pcsrc,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  alucontrol,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_RWB     = 4'd7,
        S_EXEC_I  = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    state_t      state_q, state_d;
    // run_q marks that reset=1 has been sampled at least once, so the first
    // real FETCH cycle starts one cycle after release.
    logic        run_q, run_d;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_active;
    logic        w_funct_ok;
    logic [2:0]  w_r_alu;
    logic        w_memread, w_memwrite, w_irwrite, w_pcwrite;
    logic        w_regwrite, w_done, w_illegal;
    logic        w_unused_bits;

    assign w_op          = instr[31:26];
    assign w_funct       = instr[5:0];
    assign w_active      = reset & run_q;
    assign w_unused_bits = ^instr[25:6];

    // R-type function decode: ALU code and legality
    always_comb begin
        w_r_alu    = 3'b010;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'b100001: w_r_alu = 3'b101;
            6'b100011: w_r_alu = 3'b001;
            6'b100100: w_r_alu = 3'b111;
            6'b100101: w_r_alu = 3'b110;
            6'b101011: w_r_alu = 3'b000;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // State register and reset-release tracker
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic and per-state Moore outputs
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        iord       = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        pcsrc      = 2'b00;
        w_regwrite = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_memread  = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b101;
                w_irwrite  = mem_ready;
                w_pcwrite  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b101;
                case (w_op)
                    6'b100011, 6'b101011:            state_d = S_MEMADR;
                    6'b000000:                       state_d = S_EXEC_R;
                    6'b001001, 6'b001101, 6'b001111: state_d = S_EXEC_I;
                    6'b000100, 6'b000001:            state_d = S_BRANCH;
                    6'b000010:                       state_d = S_JUMP;
                    default:                         state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b101;
                state_d    = w_op[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                w_done     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                iord       = 1'b1;
                w_done     = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alusrca    = 1'b1;
                alucontrol = w_r_alu;
                state_d    = w_funct_ok ? S_RWB : S_ILLEGAL;
            end
            S_RWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
                w_done     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (w_op)
                    6'b001001: alucontrol = 3'b101;
                    6'b001101: alucontrol = 3'b110;
                    6'b001111: alucontrol = 3'b011;
                    default:   alucontrol = 3'b010;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b001;
                pcsrc      = 2'b01;
                w_pcwrite  = (w_op == 6'b000100) ? zero : neg;
                w_done     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // ILLEGAL and unreachable codes trap until reset
                w_illegal = 1'b1;
                state_d   = S_ILLEGAL;
            end
        endcase
        if (!run_q) state_d = S_FETCH;
    end

    // Side-effecting outputs are suppressed during and just after reset
    always_comb begin
        memread    = w_memread  & w_active;
        memwrite   = w_memwrite & w_active;
        irwrite    = w_irwrite  & w_active;
        pcwrite    = w_pcwrite  & w_active;
        regwrite   = w_regwrite & w_active;
        instr_done = w_done     & w_active;
        illegal    = w_illegal  & w_active;
        state      = state_q;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
REQ-003 SHALL have port: instr  in  32  instruction register contents; op = instr[31:26], funct = instr[5:0].
REQ-004 SHALL have port: zero  in  1  ALU result equals 0.
REQ-005 SHALL have port: neg  in  1  ALU result bit 31.
REQ-006 SHALL have port: mem_ready  in  1  memory completes the current read/write this cycle.
REQ-007 SHALL have ports (all out): memread 1, memwrite 1, iord 1 (1 = ALUOut address, 0 = PC), irwrite 1, pcwrite 1, pcsrc 2 (00 ALU, 01 ALUOut, 10 jump target), regwrite 1, regdst 1 (1 = instr[15:11], 0 = instr[20:16]), memtoreg 1, alusrca 1 (0 = PC, 1 = rs), alusrcb 2 (00 rt, 01 const 4, 10 imm, 11 imm<<2), alucontrol 3, instr_done 1, illegal 1, state 4.

Function
REQ-008 SHALL use ALU codes: 101 add, 001 sub, 111 and, 110 or, 000 sltu, 011 lui, 010 undefined/don't-care.
REQ-009 SHALL implement Moore FSM states, with encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, EXEC_I 8, IWB 9, BRANCH 10, JUMP 11, ILLEGAL 15; state output = current state.
REQ-010 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=101, pcsrc=00; irwrite and pcwrite = mem_ready; stay in FETCH until mem_ready=1, then go to DECODE.
REQ-011 DECODE: alusrca=0, alusrcb=11, alucontrol=101 (branch target into ALUOut).
REQ-012 DECODE transitions by op: 100011/101011 -> MEMADR; 000000 -> EXEC_R; 001001/001101/001111 -> EXEC_I; 000100/000001 -> BRANCH; 000010 -> JUMP; any other op -> ILLEGAL.
REQ-013 MEMADR: alusrca=1, alusrcb=10, alucontrol=101; next state is MEMRD if op[3]=0, else MEMWR.
REQ-014 MEMRD: memread=1, iord=1; wait for mem_ready=1, then go to MEMWB.
REQ-015 MEMWB: regwrite=1, regdst=0, memtoreg=1; then go to FETCH.
REQ-016 MEMWR: memwrite=1, iord=1; wait for mem_ready=1, then go to FETCH.
REQ-017 EXEC_R: alusrca=1, alusrcb=00; alucontrol by funct: 100001->101, 100011->001, 100100->111, 100101->110, 101011->000, other->010.
REQ-018 EXEC_R with unsupported funct SHALL go to ILLEGAL; otherwise go to RWB.
REQ-019 RWB: regwrite=1, regdst=1, memtoreg=0; then go to FETCH.
REQ-020 EXEC_I: alusrca=1, alusrcb=10; alucontrol by op: 001001->101, 001101->110, 001111->011; then go to IWB.
REQ-021 IWB: regwrite=1, regdst=0, memtoreg=0; then go to FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, alucontrol=001, pcsrc=01; pcwrite = zero for op 000100, neg for op 000001; then go to FETCH.
REQ-023 JUMP: pcsrc=10, pcwrite=1; then go to FETCH.
REQ-024 ILLEGAL: all write/read enables 0, illegal=1; state is sticky until reset.
REQ-025 instr_done SHALL be 1 for exactly one cycle, in the last state of each instruction: MEMWB, RWB, IWB, BRANCH, JUMP, and MEMWR when mem_ready=1.
REQ-026 Outputs not listed for a state SHALL be 0.
REQ-027 memread/memwrite SHALL stay asserted, with address select stable, every cycle until mem_ready=1; mem_ready is ignored in all non-memory states.
REQ-028 Latency with mem_ready tied to 1 SHALL be: lw 5 cycles; sw, R-type, I-type 4 cycles; beq/bltz/j 3 cycles.

Reset
REQ-029 When reset=0 at a rising edge, state SHALL become FETCH, whatever the current state (including mid-wait in MEMRD/MEMWR and ILLEGAL).
REQ-030 While reset=0, memread, memwrite, irwrite, pcwrite, regwrite, instr_done and illegal SHALL be forced to 0; all other outputs are unconstrained.
REQ-031 The first FETCH after reset release SHALL assert memread in the cycle after reset=1 is first sampled.

Verification
REQ-032 Reset, then addu (op 0, funct 100001) with mem_ready=1 -> states 0,1,6,7; alucontrol=101 in state 6; regwrite=1, regdst=1 in state 7; instr_done pulses once.
REQ-033 lw with mem_ready low for 3 cycles in MEMRD -> memread=1, iord=1 held 4 cycles; MEMWB follows the mem_ready=1 cycle; total 8 cycles.
REQ-034 beq with zero=1 -> pcwrite=1, pcsrc=01 in BRANCH; repeated with zero=0 -> pcwrite=0; bltz with neg=1 -> pcwrite=1.
REQ-035 op 111111 -> ILLEGAL (15) after DECODE, illegal=1 held for 20 cycles; reset=0 -> FETCH, illegal=0.
REQ-036 reset=0 asserted during the MEMWR wait -> memwrite=0 immediately, state=0 after the edge; no instr_done pulse.
REQ-037 lui (op 001111) then ori (op 001101) -> alucontrol 011 then 110 in EXEC_I; regdst=0 in IWB.
